// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared 8N1 UART constants, receiver state encoding, baud helper
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int TIMER_W   = 16;
  localparam int INDEX_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  // Integer-truncated; callers need a result of at least 8.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_sync.sv
`default_nettype none
// ============================================================================
// rx_sync : two-flop synchronizer for the asynchronous serial line
// Revision : 1.0
// ============================================================================
module rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  // Resets to 1 so an idle line never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/receiving_rx.sv
`default_nettype none
// ============================================================================
// receiving_rx : 8N1 UART receiver with held-byte handshake, frame/overrun flags
// Revision : 1.0
// ============================================================================
module receiving_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [TIMER_W-1:0] c_BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] c_HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [INDEX_W-1:0] c_IDX_LAST  = INDEX_W'(DATA_BITS - 1);

  logic                 w_rxs;
  uart_rx_state_t       r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic [INDEX_W-1:0]   r_index;
  logic [DATA_BITS-1:0] r_shift;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;

  rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (w_rxs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_index     <= '0;
      r_shift     <= '0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // A byte completing in this same cycle overrides the clear below.
      if (rx_ack && r_valid) r_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_rxs) begin
            r_state <= ST_START;
            r_timer <= '0;
          end
        end
        ST_START: begin
          if (r_timer == c_HALF_LAST) begin
            r_timer <= '0;
            if (!w_rxs) begin
              r_state <= ST_DATA;
              r_index <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_timer == c_BIT_LAST) begin
            r_timer          <= '0;
            r_shift[r_index] <= w_rxs;
            if (r_index == c_IDX_LAST) r_state <= ST_STOP;
            else                       r_index <= r_index + 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_timer == c_BIT_LAST) begin
            r_timer <= '0;
            if (w_rxs) begin
              r_data    <= r_shift;
              r_valid   <= 1'b1;
              r_overrun <= r_valid && !rx_ack;
              r_state   <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (w_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_receiving_rx.sv
`default_nettype none
// ============================================================================
// tb_receiving_rx : directed + randomized bench for receiving_rx (CLKS_PER_BIT=16)
// Revision : 1.0
// ============================================================================
module tb_receiving_rx;

  localparam int CPB = 16;
  // Drive-to-valid: half bit + 9 bits + 1 register stage + 2 synchronizer stages.
  localparam int LAT = CPB / 2 + 9 * CPB + 1 + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  receiving_rx #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  // Drives one frame; k counts rising edges since the start bit was driven.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_k,
                            input int max_k, output int lat, output bit busy_ok);
    logic [9:0] bits;
    logic       prev_v;
    int         k;
    bits    = {stop, b, 1'b0};
    lat     = -1;
    busy_ok = 1'b1;
    k       = 0;
    prev_v  = rx_valid;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < CPB; j++) begin
        if (ack_k > 0) rx_ack = (k == ack_k);
        @(negedge clk);
        k++;
        if (k >= 3 && k <= LAT - 1 && busy !== 1'b1) busy_ok = 1'b0;
        if (lat < 0 && rx_valid === 1'b1 && prev_v !== 1'b1) lat = k;
        prev_v = rx_valid;
        if (max_k > 0 && k >= max_k) return;
      end
    end
    if (ack_k > 0) rx_ack = 1'b0;
  endtask

  initial begin
    int         lat;
    bit         bok;
    int         fe0, ov0;
    logic [7:0] b;
    logic       st;
    logic [7:0] exp_data;
    bit         pending;
    int         exp_fe, exp_ov;

    // Reset state
    tick(5);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick(4);

    // Clean frame, latency and busy window
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, 0, 0, lat, bok);
    tick(4);
    tests++;
    assert (lat >= LAT - 1 && lat <= LAT + 1) else begin
      fails++;
      $error("FAIL a5_latency observed=%0d expected=%0d+-1", lat, LAT);
    end
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", rx_valid, 1);
    check("a5_busy_window", bok, 1);
    check("a5_no_frame_err", fe_cnt - fe0, 0);
    ack_pulse();
    check("a5_ack_clears", rx_valid, 0);

    // Start-bit glitch is discarded
    fe0 = fe_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    check("glitch_busy", busy, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);
    send_frame(8'h3C, 1'b1, 0, 0, lat, bok);
    tick(4);
    check("3c_data", rx_data, 8'h3C);
    check("3c_valid", rx_valid, 1);
    ack_pulse();

    // Framing error with line held low
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 0, 0, lat, bok);
    tick(40);
    check("fe_pulse_count", fe_cnt - fe0, 1);
    check("fe_valid", rx_valid, 0);
    check("fe_data_kept", rx_data, 8'h3C);
    check("fe_wait_high_busy", busy, 1);
    rx = 1'b1;
    tick(4);
    check("fe_release_idle", busy, 0);

    // Overrun
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 0, 0, lat, bok);
    tick(3);
    send_frame(8'h22, 1'b1, 0, 0, lat, bok);
    tick(3);
    check("ov_count", ov_cnt - ov0, 1);
    check("ov_data", rx_data, 8'h22);
    check("ov_valid", rx_valid, 1);
    ack_pulse();
    check("ov_ack_clears", rx_valid, 0);

    // Ack in the completion cycle: new byte wins, no overrun
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 0, 0, lat, bok);
    tick(3);
    send_frame(8'h77, 1'b1, LAT - 1, 0, lat, bok);
    tick(3);
    check("ackcoll_valid", rx_valid, 1);
    check("ackcoll_data", rx_data, 8'h77);
    check("ackcoll_no_overrun", ov_cnt - ov0, 0);
    ack_pulse();

    // Reset mid-frame during data bit 3
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'hF0, 1'b1, 0, 4 * CPB + 8, lat, bok);
    reset = 1'b1;
    rx = 1'b1;
    tick(3);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    tick(3);
    send_frame(8'h0F, 1'b1, 0, 0, lat, bok);
    tick(3);
    check("midrst_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("after_rst_data", rx_data, 8'h0F);
    check("after_rst_valid", rx_valid, 1);
    ack_pulse();

    // Randomized frames against a byte-level model
    exp_data = 8'h0F;
    pending  = 1'b0;
    exp_fe   = 0;
    exp_ov   = 0;
    fe0      = fe_cnt;
    ov0      = ov_cnt;
    for (int n = 0; n < 10; n++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      send_frame(b, st, 0, 0, lat, bok);
      rx = 1'b1;
      tick($urandom_range(3, 8));
      if (st) begin
        if (pending) exp_ov++;
        exp_data = b;
        pending  = 1'b1;
      end else begin
        exp_fe++;
      end
      check("rnd_data", rx_data, exp_data);
      check("rnd_valid", rx_valid, pending);
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        pending = 1'b0;
      end
    end
    check("rnd_overrun_count", ov_cnt - ov0, exp_ov);
    check("rnd_frame_err_count", fe_cnt - fe0, exp_fe);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
